// File: rtl/game_timer_fsm.sv
// Snake game timer: IDLE/RUN/PAUSE/OVER control with run-cycle counter
// and a saturating MM:SS BCD clock for the LCD stage.
module game_timer_fsm #(
  parameter int CLK_FREQ = 25000000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        start,
  input  logic        pause_req,
  input  logic        snake_dead,
  input  logic        restart,
  output logic [1:0]  lcd_state,
  output logic [31:0] game_timer,
  output logic [7:0]  min_bcd,
  output logic [7:0]  sec_bcd,
  output logic        disp_update
);

  localparam int PW = $clog2(CLK_FREQ);
  localparam logic [PW-1:0] PS_MAX = PW'(CLK_FREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    OVER
  } state_t;

  state_t        state;
  logic [PW-1:0] prescale;
  logic          wrap;
  logic          at_max;
  logic [7:0]    sec_next;
  logic [7:0]    min_next;

  assign wrap   = (prescale == PS_MAX);
  assign at_max = (min_bcd == 8'h99) && (sec_bcd == 8'h59);

  // Next MM:SS value for a one-second tick, digit by digit in BCD.
  always_comb begin
    sec_next = sec_bcd;
    min_next = min_bcd;
    if (sec_bcd == 8'h59) begin
      sec_next = 8'h00;
      if (min_bcd[3:0] == 4'd9)
        min_next = {min_bcd[7:4] + 4'd1, 4'd0};
      else
        min_next = {min_bcd[7:4], min_bcd[3:0] + 4'd1};
    end else if (sec_bcd[3:0] == 4'd9) begin
      sec_next = {sec_bcd[7:4] + 4'd1, 4'd0};
    end else begin
      sec_next = {sec_bcd[7:4], sec_bcd[3:0] + 4'd1};
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= IDLE;
      lcd_state   <= 2'b00;
      game_timer  <= '0;
      prescale    <= '0;
      min_bcd     <= 8'h00;
      sec_bcd     <= 8'h00;
      disp_update <= 1'b0;
    end else begin
      disp_update <= 1'b0;
      if (restart) begin
        state       <= IDLE;
        lcd_state   <= 2'b00;
        disp_update <= (state != IDLE);
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state       <= RUN;
              game_timer  <= '0;
              prescale    <= '0;
              min_bcd     <= 8'h00;
              sec_bcd     <= 8'h00;
              disp_update <= 1'b1;
            end
          end
          RUN: begin
            if (game_timer != 32'hFFFF_FFFF)
              game_timer <= game_timer + 32'd1;
            if (wrap) begin
              prescale <= '0;
              // At 99:59 the tick is swallowed so the display stops changing.
              if (!at_max) begin
                sec_bcd     <= sec_next;
                min_bcd     <= min_next;
                disp_update <= 1'b1;
              end
            end else begin
              prescale <= prescale + PW'(1);
            end
            if (snake_dead) begin
              state       <= OVER;
              lcd_state   <= 2'b01;
              disp_update <= 1'b1;
            end else if (pause_req) begin
              state       <= PAUSE;
              disp_update <= 1'b1;
            end
          end
          PAUSE: begin
            if (pause_req) begin
              state       <= RUN;
              disp_update <= 1'b1;
            end
          end
          OVER: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_timer_fsm.sv
// Bench for game_timer_fsm: two instances (CLK_FREQ 10 and 2) on shared
// stimulus, checked every cycle against a run-time based model.
module tb_game_timer_fsm;

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] ST   = 4'b1000;
  localparam logic [3:0] PS   = 4'b0100;
  localparam logic [3:0] DD   = 4'b0010;
  localparam logic [3:0] RS   = 4'b0001;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_OVER  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic pause_req = 1'b0;
  logic snake_dead = 1'b0;
  logic restart = 1'b0;

  logic [1:0]  lcd_a, lcd_b;
  logic [31:0] gt_a, gt_b;
  logic [7:0]  min_a, min_b, sec_a, sec_b;
  logic        du_a, du_b;

  int checks = 0;
  int failures = 0;
  int du_cnt10 = 0;
  int du_cnt2 = 0;

  int     mode[2];
  longint runc[2];
  logic   exp_du[2];

  always #5 clk = ~clk;

  game_timer_fsm #(.CLK_FREQ(10)) u10 (
    .iCLK(clk), .iRST_N(rst_n),
    .start(start), .pause_req(pause_req),
    .snake_dead(snake_dead), .restart(restart),
    .lcd_state(lcd_a), .game_timer(gt_a),
    .min_bcd(min_a), .sec_bcd(sec_a),
    .disp_update(du_a)
  );

  game_timer_fsm #(.CLK_FREQ(2)) u2 (
    .iCLK(clk), .iRST_N(rst_n),
    .start(start), .pause_req(pause_req),
    .snake_dead(snake_dead), .restart(restart),
    .lcd_state(lcd_b), .game_timer(gt_b),
    .min_bcd(min_b), .sec_bcd(sec_b),
    .disp_update(du_b)
  );

  function automatic int freq_of(input int i);
    return (i == 0) ? 10 : 2;
  endfunction

  // Displayed seconds follow run time alone, capped at 99:59.
  function automatic int shown(input int i);
    longint s;
    s = runc[i] / freq_of(i);
    if (s > 5999) s = 5999;
    return int'(s);
  endfunction

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = M_IDLE;
      runc[i] = 0;
      exp_du[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [3:0] v);
    int pm, ps;
    for (int i = 0; i < 2; i++) begin
      pm = mode[i];
      ps = shown(i);
      if (v[0]) begin
        mode[i] = M_IDLE;
      end else begin
        case (mode[i])
          M_IDLE: if (v[3]) begin mode[i] = M_RUN; runc[i] = 0; end
          M_RUN: begin
            runc[i]++;
            if (v[1]) mode[i] = M_OVER;
            else if (v[2]) mode[i] = M_PAUSE;
          end
          M_PAUSE: if (v[2]) mode[i] = M_RUN;
          default: ;
        endcase
      end
      exp_du[i] = (mode[i] != pm) || (shown(i) != ps);
    end
  endtask

  task automatic compare_all();
    int s;
    logic [31:0] t;
    for (int i = 0; i < 2; i++) begin
      s = shown(i);
      t = (runc[i] > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : runc[i][31:0];
      chk($sformatf("u%0d lcd_state", freq_of(i)),
          {30'd0, (i == 0) ? lcd_a : lcd_b},
          (mode[i] == M_OVER) ? 32'd1 : 32'd0);
      chk($sformatf("u%0d game_timer", freq_of(i)),
          (i == 0) ? gt_a : gt_b, t);
      chk($sformatf("u%0d min_bcd", freq_of(i)),
          {24'd0, (i == 0) ? min_a : min_b}, {24'd0, bcd(s / 60)});
      chk($sformatf("u%0d sec_bcd", freq_of(i)),
          {24'd0, (i == 0) ? sec_a : sec_b}, {24'd0, bcd(s % 60)});
      chk($sformatf("u%0d disp_update", freq_of(i)),
          {31'd0, (i == 0) ? du_a : du_b}, {31'd0, exp_du[i]});
    end
  endtask

  task automatic go(input logic [3:0] v);
    {start, pause_req, snake_dead, restart} = v;
    @(posedge clk);
    model_step(v);
    #1;
    compare_all();
    if (du_a) du_cnt10++;
    if (du_b) du_cnt2++;
    {start, pause_req, snake_dead, restart} = NONE;
  endtask

  task automatic idle(input int n);
    repeat (n) go(NONE);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [3:0]  in;
    logic [1:0]  lcd;
    logic [31:0] t;
    logic [7:0]  sec;
    logic        du;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [3:0] v;
    int r;

    tbl[0]  = '{NONE, 2'd0, 32'd0, 8'h00, 1'b0};
    tbl[1]  = '{PS,   2'd0, 32'd0, 8'h00, 1'b0};
    tbl[2]  = '{DD,   2'd0, 32'd0, 8'h00, 1'b0};
    tbl[3]  = '{ST|PS, 2'd0, 32'd0, 8'h00, 1'b1};
    tbl[4]  = '{NONE, 2'd0, 32'd1, 8'h00, 1'b0};
    tbl[5]  = '{PS,   2'd0, 32'd2, 8'h00, 1'b1};
    tbl[6]  = '{NONE, 2'd0, 32'd2, 8'h00, 1'b0};
    tbl[7]  = '{ST,   2'd0, 32'd2, 8'h00, 1'b0};
    tbl[8]  = '{DD,   2'd0, 32'd2, 8'h00, 1'b0};
    tbl[9]  = '{PS,   2'd0, 32'd2, 8'h00, 1'b1};
    tbl[10] = '{NONE, 2'd0, 32'd3, 8'h00, 1'b0};
    tbl[11] = '{DD,   2'd1, 32'd4, 8'h00, 1'b1};
    tbl[12] = '{PS,   2'd1, 32'd4, 8'h00, 1'b0};
    tbl[13] = '{ST,   2'd1, 32'd4, 8'h00, 1'b0};
    tbl[14] = '{ST|RS, 2'd0, 32'd4, 8'h00, 1'b1};
    tbl[15] = '{RS,   2'd0, 32'd4, 8'h00, 1'b0};
    tbl[16] = '{ST,   2'd0, 32'd0, 8'h00, 1'b1};
    tbl[17] = '{NONE, 2'd0, 32'd1, 8'h00, 1'b0};

    do_reset();

    for (int k = 0; k < 18; k++) begin
      go(tbl[k].in);
      chk($sformatf("tbl%0d lcd", k), {30'd0, lcd_a}, {30'd0, tbl[k].lcd});
      chk($sformatf("tbl%0d timer", k), gt_a, tbl[k].t);
      chk($sformatf("tbl%0d sec", k), {24'd0, sec_a}, {24'd0, tbl[k].sec});
      chk($sformatf("tbl%0d du", k), {31'd0, du_a}, {31'd0, tbl[k].du});
    end

    // 25 run cycles at 10 Hz: two second ticks plus the RUN entry pulse
    go(RS);
    du_cnt10 = 0;
    go(ST);
    idle(25);
    chk("run25 timer", gt_a, 32'd25);
    chk("run25 sec", {24'd0, sec_a}, 32'h02);
    chk("run25 pulses", du_cnt10, 32'd3);

    // minute rollover lands on the same edge
    go(RS);
    go(ST);
    idle(599);
    chk("0059 min", {24'd0, min_a}, 32'h00);
    chk("0059 sec", {24'd0, sec_a}, 32'h59);
    go(NONE);
    chk("0100 min", {24'd0, min_a}, 32'h01);
    chk("0100 sec", {24'd0, sec_a}, 32'h00);
    chk("0100 du", {31'd0, du_a}, 32'd1);

    // pause edge yields 7, holds 7, resume then 8
    go(RS);
    go(ST);
    idle(6);
    go(PS);
    chk("pause timer", gt_a, 32'd7);
    for (int k = 0; k < 50; k++) begin
      go(NONE);
      chk("paused hold", gt_a, 32'd7);
    end
    go(PS);
    chk("resume edge", gt_a, 32'd7);
    go(NONE);
    chk("resumed", gt_a, 32'd8);

    // restart overrides snake_dead; then death alone freezes
    go(RS);
    go(ST);
    idle(3);
    go(DD | RS);
    chk("dead+restart lcd", {30'd0, lcd_a}, 32'd0);
    idle(2);
    chk("idle frozen", gt_a, 32'd3);
    go(ST);
    idle(3);
    go(DD);
    chk("dead lcd", {30'd0, lcd_a}, 32'd1);
    idle(5);
    chk("dead frozen", gt_a, 32'd4);

    // death coinciding with a second tick keeps the tick
    go(RS);
    go(ST);
    idle(9);
    go(DD);
    chk("tick+dead sec", {24'd0, sec_a}, 32'h01);
    chk("tick+dead lcd", {30'd0, lcd_a}, 32'd1);

    // pause coinciding with a second tick keeps the tick
    go(RS);
    go(ST);
    idle(9);
    go(PS);
    chk("tick+pause sec", {24'd0, sec_a}, 32'h01);
    idle(3);
    chk("tick+pause hold", gt_a, 32'd10);

    // asynchronous reset mid-run, then clean restart
    go(RS);
    go(ST);
    idle(30);
    do_reset();
    chk("rst gt", gt_a, 32'd0);
    chk("rst sec", {24'd0, sec_a}, 32'd0);
    go(NONE);
    chk("release no pulse", {31'd0, du_a}, 32'd0);
    go(ST);
    chk("after rst min", {24'd0, min_a}, 32'd0);
    chk("after rst sec", {24'd0, sec_a}, 32'd0);
    idle(10);
    chk("after rst tick", {24'd0, sec_a}, 32'h01);

    // 2 Hz instance runs past 99:59 and saturates
    go(RS);
    go(ST);
    idle(12000);
    du_cnt2 = 0;
    idle(100);
    chk("sat min", {24'd0, min_b}, 32'h99);
    chk("sat sec", {24'd0, sec_b}, 32'h59);
    chk("sat timer", gt_b, 32'd12100);
    chk("sat no pulse", du_cnt2, 32'd0);

    // random control pulses against the model
    go(RS);
    for (int k = 0; k < 2000; k++) begin
      r = int'($urandom_range(0, 99));
      v[3] = (r < 12);
      r = int'($urandom_range(0, 99));
      v[2] = (r < 8);
      r = int'($urandom_range(0, 99));
      v[1] = (r < 3);
      r = int'($urandom_range(0, 99));
      v[0] = (r < 2);
      go(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_timer_fsm.md
GAME_TIMER_FSM -- requirements
Module: game_timer_fsm

Interface
REQ-001 Parameter: CLK_FREQ, 25000000, iCLK cycles per game second; legal range is 2 or more.
REQ-002 Port: iCLK  input  1  sole clock; all logic on rising edge.
REQ-003 Port: iRST_N  input  1  reset; asynchronous, active-low.
REQ-004 Port: start  input  1  one-cycle pulse; begin a game.
REQ-005 Port: pause_req  input  1  one-cycle pulse; toggle between running and paused.
REQ-006 Port: snake_dead  input  1  one-cycle pulse; collision detected.
REQ-007 Port: restart  input  1  one-cycle pulse; return to idle.
REQ-008 Port: lcd_state  output  2  00 = game start/in progress, 01 = game over; feeds the LCD message stage.
REQ-009 Port: game_timer  output  32  count of iCLK cycles spent in RUN since the game began.
REQ-010 Port: min_bcd  output  8  minutes as two BCD digits, [7:4] tens and [3:0] ones.
REQ-011 Port: sec_bcd  output  8  seconds as two BCD digits, [7:4] tens and [3:0] ones.
REQ-012 Port: disp_update  output  1  one-cycle pulse; the display content has changed.

Function
REQ-013 The block SHALL implement four states: IDLE, RUN, PAUSE, OVER; all outputs registered.
REQ-014 IDLE SHALL go to RUN on start; entering RUN from IDLE SHALL clear game_timer, the prescaler, min_bcd and sec_bcd to 0 in the same edge.
REQ-015 RUN SHALL go to OVER on snake_dead; otherwise RUN SHALL go to PAUSE on pause_req.
REQ-016 PAUSE SHALL go to RUN on pause_req; snake_dead and start SHALL be ignored in PAUSE.
REQ-017 OVER SHALL ignore start, pause_req and snake_dead.
REQ-018 restart SHALL move any state to IDLE on the next edge and SHALL override every other input in the same cycle.
REQ-019 In IDLE, start and pause_req asserted together SHALL enter RUN, and pause_req SHALL be ignored.
REQ-020 lcd_state SHALL be 01 in OVER and 00 in every other state.
REQ-021 In RUN, game_timer SHALL increment by 1 per cycle and saturate at 32'hFFFFFFFF; in PAUSE, OVER and IDLE it SHALL hold.
REQ-022 Prescaler: counts 0..CLK_FREQ-1 in RUN only; holds in PAUSE and OVER.
REQ-023 Prescaler wrap: when it wraps CLK_FREQ-1 -> 0, the seconds value SHALL advance by one on that edge.
REQ-024 Seconds SHALL count 00..59 in BCD; a second tick at 59 SHALL give sec_bcd 00 and min_bcd+1, in the same edge.
REQ-025 Minutes SHALL count 00..99 in BCD; at 99:59 further second ticks SHALL hold 99:59 (saturate).
REQ-026 BCD digits SHALL never hold A-F.
REQ-027 disp_update SHALL pulse for exactly one cycle, registered and coincident with the new output values, on these events:
  - every seconds change;
  - every state change.
REQ-028 Two events in the same cycle SHALL produce a single disp_update pulse.
REQ-029 A snake_dead on the same edge as a second tick SHALL still apply the tick, then freeze in OVER.
REQ-030 A pause_req on the same edge as a second tick SHALL still apply the tick, then freeze in PAUSE.

Reset
REQ-031 While iRST_N=0 these outputs SHALL hold their reset values regardless of iCLK: state IDLE, lcd_state 00, game_timer 0, prescaler 0, min_bcd 00, sec_bcd 00, disp_update 0.
REQ-032 Deassertion of iRST_N SHALL take effect at the next rising edge of iCLK; the first edge after release SHALL NOT pulse disp_update.
REQ-033 Reset asserted mid-game SHALL discard all progress, with no other side effect.

Verification
REQ-034 Scenario: CLK_FREQ=10, start, run 25 cycles -> game_timer=25, sec_bcd=8'h02, two disp_update pulses from seconds plus one from entering RUN.
REQ-035 Scenario: CLK_FREQ=10, run to 00:59 then 10 more cycles -> min_bcd=8'h01, sec_bcd=8'h00 on the same edge.
REQ-036 Scenario: CLK_FREQ=2, run past 99:59 -> outputs hold 8'h99/8'h59 and disp_update stops pulsing; game_timer still increments.
REQ-037 Scenario: pause_req at game_timer=7, wait 50 cycles, pause_req -> game_timer stays 7 while paused and resumes at 8.
REQ-038 Scenario: snake_dead and restart in the same cycle during RUN -> IDLE, lcd_state=00; snake_dead alone -> lcd_state=01 with the timer frozen.
REQ-039 Scenario: iRST_N low mid-RUN with no clock edge -> all outputs 0 immediately; after release, start restarts from 00:00.
